nx_cy_pipe_add: RTL and testbench
=================================

NX_CY_PIPE_ADD -- requirements
Module: nx_cy_pipe_add

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand/result width; it SHALL be a multiple of 4 and at least 8.
REQ-002 The block SHALL have parameter SLICES_PER_STAGE, default 2, giving the number of 4-bit carry slices evaluated per pipeline stage; it SHALL be at least 1.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows:
- CK  input  1  clock; all state updates on its rising edge.
- R  input  1  synchronous active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CI  input  1  carry-in.
- BI  input  1  invert B (1 = subtract, with CI=1).
- IN_VALID  input  1  operand beat valid.
- IN_READY  output  1  block accepts a beat this cycle.
- Y  output  WIDTH  sum A + (BI ? ~B : B) + CI, modulo 2^WIDTH.
- CO  output  1  carry out of bit WIDTH-1.
- V  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- OUT_VALID  output  1  Y/CO/V hold a result.
- OUT_READY  input  1  downstream accepts the result.

Function
REQ-004 NSTAGES SHALL equal ceil(WIDTH / (4*SLICES_PER_STAGE)); stage k SHALL resolve bits [4*SPS*k, min(4*SPS*(k+1), WIDTH)-1] using the registered carry from stage k-1 (stage 0 uses CI).
REQ-005 Each stage SHALL add 4-bit slices as a ripple of generate/propagate terms on AA=A and BB=(BI ? ~B : B), with no carry-lookahead across slice boundaries inside a stage.
REQ-006 Each stage register SHALL hold: a valid bit, the already-resolved low sum bits, the not-yet-used high bits of AA and BB, the outgoing carry, and (final stage only) the carry into the MSB.
REQ-007 Input-to-output latency SHALL be exactly NSTAGES cycles when no stall occurs: a beat accepted at edge t SHALL present OUT_VALID=1 after edge t+NSTAGES-1.
REQ-008 A beat SHALL be accepted on an edge where IN_VALID=1 and IN_READY=1; otherwise a bubble (valid=0) SHALL enter stage 0.
REQ-009 Stall SHALL be defined as OUT_VALID=1 and OUT_READY=0; while stalled, every stage register SHALL hold its value and IN_READY SHALL be 0.
REQ-010 IN_READY SHALL equal NOT stall (combinational from OUT_VALID, OUT_READY); bubbles SHALL NOT be squeezed out during a stall.
REQ-011 Y, CO and V SHALL be driven directly from the final stage register and SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-012 When OUT_VALID=0, Y/CO/V values are don't-care to the consumer but SHALL still be deterministic (register contents).
REQ-013 Arithmetic SHALL wrap modulo 2^WIDTH; CO SHALL be the unsigned carry (for BI=1, CI=1, CO=1 means A >= B unsigned).
REQ-014 Back-to-back beats SHALL sustain one result per cycle when OUT_READY is held 1.
REQ-015 Operands SHALL be sampled only on accepting edges; changes on A/B/CI/BI at other times SHALL not affect results in flight.

Reset
REQ-016 On an edge with R=0, all stage valid bits SHALL clear to 0 and all data/carry registers SHALL clear to 0, so OUT_VALID=0, Y=0, CO=0, V=0 after that edge.
REQ-017 During R=0, IN_READY SHALL be 0 and no beat SHALL be accepted.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight beats; no partial result SHALL emerge after R returns to 1.
REQ-019 The first beat SHALL be accepted on the first edge with R=1 and IN_VALID=1.

Verification (WIDTH=16, SLICES_PER_STAGE=2, NSTAGES=2)
REQ-020 Basic add: A=0x1234, B=0x0FFF, CI=0, BI=0, OUT_READY=1 -> two edges later Y=0x2233, CO=0, V=0, OUT_VALID=1 for one cycle.
REQ-021 Cross-stage carry and wrap: A=0xFFFF, B=0x0001, CI=0 -> Y=0x0000, CO=1, V=0; A=0x7FFF, B=0x0001 -> Y=0x8000, CO=0, V=1.
REQ-022 Subtract: A=0x0005, B=0x0007, BI=1, CI=1 -> Y=0xFFFE, CO=0; A=0x0007, B=0x0005 -> Y=0x0002, CO=1.
REQ-023 Backpressure: stream 4 beats (0+1, 1+1, 2+1, 3+1) with OUT_READY=0 for 3 cycles after first OUT_VALID -> IN_READY=0 while stalled, Y held at 0x0001, then results 0x0001..0x0004 emerge in order, none lost or duplicated.
REQ-024 Reset mid-flight: accept beat A=0x00FF, B=0x0001, assert R=0 on the next edge -> OUT_VALID stays 0 for all following cycles until a new beat is accepted after R=1.
REQ-025 Throughput: 100 random beats with IN_VALID=1 and OUT_READY=1 throughout -> 100 results on 100 consecutive cycles, each matching (A + (BI?~B:B) + CI) mod 2^16 with correct CO and V.

Source files
------------

// File: rtl/nx_cy_pipe_add.sv
// Pipelined carry-ripple adder/subtractor: each stage resolves SLICES_PER_STAGE
// 4-bit slices and hands its carry and the unused operand bits to the next stage.
module nx_cy_pipe_add #(
    parameter int WIDTH            = 16,
    parameter int SLICES_PER_STAGE = 2
) (
    input  logic             CK,
    input  logic             R,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             BI,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] Y,
    output logic             CO,
    output logic             V,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int SPAN    = 4 * SLICES_PER_STAGE;
    localparam int NSTAGES = (WIDTH + SPAN - 1) / SPAN;
    localparam int NMID    = (NSTAGES > 1) ? NSTAGES - 1 : 1;

    // Stage registers; operand bits are only carried into stages that still need them.
    logic [NSTAGES-1:0] st_vld;
    logic [NSTAGES-1:0] st_cy;
    logic [WIDTH-1:0]   st_sum [NSTAGES];
    logic [WIDTH-1:0]   st_aa  [NMID];
    logic [WIDTH-1:0]   st_bb  [NMID];
    logic               st_msb_cy;

    logic [NSTAGES-1:0] src_vld;
    logic [NSTAGES-1:0] src_cy;
    logic [WIDTH-1:0]   src_sum [NSTAGES];
    logic [WIDTH-1:0]   src_aa  [NSTAGES];
    logic [WIDTH-1:0]   src_bb  [NSTAGES];

    logic [NSTAGES-1:0] nx_cy;
    logic [WIDTH-1:0]   nx_sum [NSTAGES];
    logic [WIDTH-1:0]   nx_aa  [NMID];
    logic [WIDTH-1:0]   nx_bb  [NMID];
    logic               nx_msb_cy;

    logic [WIDTH-1:0]   t_a;
    logic [WIDTH-1:0]   t_b;
    logic [WIDTH-1:0]   t_s;
    logic               t_c;

    logic stall;
    logic accept;

    assign stall     = st_vld[NSTAGES-1] & ~OUT_READY;
    assign IN_READY  = R & ~stall;
    assign accept    = IN_VALID & IN_READY;

    assign Y         = st_sum[NSTAGES-1];
    assign CO        = st_cy[NSTAGES-1];
    assign V         = st_msb_cy ^ st_cy[NSTAGES-1];
    assign OUT_VALID = st_vld[NSTAGES-1];

    // Stage k consumes stage k-1's register; stage 0 consumes the ports.
    always_comb begin
        src_vld[0] = accept;
        src_cy[0]  = CI;
        src_sum[0] = '0;
        src_aa[0]  = A;
        src_bb[0]  = BI ? ~B : B;
        for (int unsigned k = 1; k < NSTAGES; k++) begin
            src_vld[k] = st_vld[k-1];
            src_cy[k]  = st_cy[k-1];
            src_sum[k] = st_sum[k-1];
            src_aa[k]  = st_aa[k-1];
            src_bb[k]  = st_bb[k-1];
        end
    end

    always_comb begin
        nx_msb_cy = 1'b0;
        nx_cy     = '0;
        t_a       = '0;
        t_b       = '0;
        t_s       = '0;
        t_c       = 1'b0;
        for (int unsigned j = 0; j < NMID; j++) begin
            nx_aa[j] = '0;
            nx_bb[j] = '0;
        end
        for (int unsigned k = 0; k < NSTAGES; k++) begin
            t_a = src_aa[k];
            t_b = src_bb[k];
            t_s = src_sum[k];
            t_c = src_cy[k];
            // Plain generate/propagate ripple over this stage's bit window.
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (i >= k * SPAN && i < (k + 1) * SPAN) begin
                    if (i == WIDTH - 1)
                        nx_msb_cy = t_c;
                    t_s[i] = t_a[i] ^ t_b[i] ^ t_c;
                    t_c    = (t_a[i] & t_b[i]) | ((t_a[i] ^ t_b[i]) & t_c);
                    t_a[i] = 1'b0;
                    t_b[i] = 1'b0;
                end
            end
            nx_sum[k] = t_s;
            nx_cy[k]  = t_c;
            if (k < NSTAGES - 1) begin
                nx_aa[k] = t_a;
                nx_bb[k] = t_b;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (!R) begin
            st_vld    <= '0;
            st_cy     <= '0;
            st_msb_cy <= 1'b0;
            for (int unsigned k = 0; k < NSTAGES; k++)
                st_sum[k] <= '0;
            for (int unsigned j = 0; j < NMID; j++) begin
                st_aa[j] <= '0;
                st_bb[j] <= '0;
            end
        end else if (!stall) begin
            st_vld <= src_vld;
            // Stage 0 data only moves on accepting edges; bubbles keep old contents.
            for (int unsigned k = 0; k < NSTAGES; k++) begin
                if (k != 0 || accept) begin
                    st_sum[k] <= nx_sum[k];
                    st_cy[k]  <= nx_cy[k];
                    if (k < NSTAGES - 1) begin
                        st_aa[k] <= nx_aa[k];
                        st_bb[k] <= nx_bb[k];
                    end
                end
            end
            if (NSTAGES > 1 || accept)
                st_msb_cy <= nx_msb_cy;
        end
    end

endmodule

// File: tb/tb_nx_cy_pipe_add.sv
// Directed bench for nx_cy_pipe_add at WIDTH=16, SLICES_PER_STAGE=2 (two stages).
module tb_nx_cy_pipe_add;

    logic        CK = 1'b0;
    logic        R;
    logic [15:0] A;
    logic [15:0] B;
    logic        CI;
    logic        BI;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] Y;
    logic        CO;
    logic        V;
    logic        OUT_VALID;
    logic        OUT_READY;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [15:0] ra  [100];
    logic [15:0] rb  [100];
    logic        rci [100];
    logic        rbi [100];

    nx_cy_pipe_add #(.WIDTH(16), .SLICES_PER_STAGE(2)) dut (
        .CK(CK), .R(R), .A(A), .B(B), .CI(CI), .BI(BI),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .Y(Y), .CO(CO), .V(V),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    always #5 CK = ~CK;

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packed as {OUT_VALID, CO, V, Y}
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic bi);
        logic [15:0] bb;
        logic [16:0] s;
        logic        v;
        bb = bi ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {16'd0, ci};
        v  = (a[15] == bb[15]) && (s[15] != a[15]);
        return {1'b1, s[16], v, s[15:0]};
    endfunction

    task automatic send(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic bi,
                        input logic [15:0] ey, input logic eco, input logic ev);
        A = a; B = b; CI = ci; BI = bi; IN_VALID = 1'b1;
        tick;
        IN_VALID = 1'b0;
        A = 16'hDEAD; B = 16'hBEEF; CI = ~ci; BI = ~bi;
        chk({tag, "_lat1"}, {31'd0, OUT_VALID}, 32'd0);
        tick;
        chk(tag, {13'd0, OUT_VALID, CO, V, Y}, {13'd0, 1'b1, eco, ev, ey});
        tick;
        chk({tag, "_once"}, {31'd0, OUT_VALID}, 32'd0);
    endtask

    initial begin
        R = 1'b0; A = '0; B = '0; CI = 1'b0; BI = 1'b0;
        IN_VALID = 1'b1; OUT_READY = 1'b1;
        tick;
        tick;
        chk("reset_out", {13'd0, OUT_VALID, CO, V, Y}, 32'd0);
        chk("reset_in_ready", {31'd0, IN_READY}, 32'd0);
        IN_VALID = 1'b0;
        R = 1'b1;
        #1;
        chk("ready_after_reset", {31'd0, IN_READY}, 32'd1);

        send("add_basic",  16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        send("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send("sub_neg",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send("sub_pos",    16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        send("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send("add_ci",     16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Backpressure: four beats i+1, output stalled for three cycles
        B = 16'h0001; CI = 1'b0; BI = 1'b0;
        A = 16'h0000; IN_VALID = 1'b1;
        tick;
        A = 16'h0001;
        tick;
        OUT_READY = 1'b0;
        A = 16'h0002;
        #1;
        chk("bp_ready0", {31'd0, IN_READY}, 32'd0);
        chk("bp_hold0", {15'd0, OUT_VALID, Y}, {15'd0, 1'b1, 16'h0001});
        tick;
        chk("bp_ready1", {31'd0, IN_READY}, 32'd0);
        chk("bp_hold1", {15'd0, OUT_VALID, Y}, {15'd0, 1'b1, 16'h0001});
        tick;
        chk("bp_hold2", {15'd0, OUT_VALID, Y}, {15'd0, 1'b1, 16'h0001});
        OUT_READY = 1'b1;
        #1;
        chk("bp_release", {31'd0, IN_READY}, 32'd1);
        tick;
        chk("bp_res2", {15'd0, OUT_VALID, Y}, {15'd0, 1'b1, 16'h0002});
        A = 16'h0003;
        tick;
        chk("bp_res3", {15'd0, OUT_VALID, Y}, {15'd0, 1'b1, 16'h0003});
        IN_VALID = 1'b0;
        tick;
        chk("bp_res4", {15'd0, OUT_VALID, Y}, {15'd0, 1'b1, 16'h0004});
        tick;
        chk("bp_drain", {31'd0, OUT_VALID}, 32'd0);

        // Reset while a beat is in flight
        A = 16'h00FF; B = 16'h0001; CI = 1'b0; BI = 1'b0; IN_VALID = 1'b1;
        tick;
        IN_VALID = 1'b0;
        R = 1'b0;
        tick;
        chk("midrst_out", {13'd0, OUT_VALID, CO, V, Y}, 32'd0);
        chk("midrst_ready", {31'd0, IN_READY}, 32'd0);
        R = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("midrst_quiet", {31'd0, OUT_VALID}, 32'd0);
        end
        send("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Throughput: 100 random beats back to back
        for (int i = 0; i < 100; i++) begin
            ra[i]  = 16'($urandom);
            rb[i]  = 16'($urandom);
            rci[i] = 1'($urandom);
            rbi[i] = 1'($urandom);
        end
        ra[0] = 16'h8000; rb[0] = 16'h8000; rci[0] = 1'b0; rbi[0] = 1'b0;
        for (int c = 0; c <= 100; c++) begin
            if (c < 100) begin
                A = ra[c]; B = rb[c]; CI = rci[c]; BI = rbi[c]; IN_VALID = 1'b1;
            end else begin
                IN_VALID = 1'b0;
            end
            tick;
            if (c >= 1)
                chk("stream", {13'd0, OUT_VALID, CO, V, Y},
                    {13'd0, model(ra[c-1], rb[c-1], rci[c-1], rbi[c-1])});
        end
        tick;
        chk("stream_end", {31'd0, OUT_VALID}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
